// File: rtl/prime_job_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : prime_job_ctrl
//  Purpose  : Bus-mapped sequencer for an external iterative primality engine.
//             A job write of A walks candidates 2,3,4,... through the engine
//             until A primes have been found. The block records the last prime
//             (W), the number found, a status code and a small result FIFO.
//             The prime counts of completed jobs are summed onto gpio_out.
//  Ports    : clk, n_reset      - clock, asynchronous active-low reset
//             saddress/srd/swr  - bus address and level strobes (edge-detected)
//             sdata_in/out      - bus write data / registered read data
//             eng_start/cand    - start pulse and candidate to the engine
//             eng_ready/done/is_prime - engine handshake and result
//             gpio_out          - {16'h0, running sum of primes found}
//             irq               - one-cycle pulse on completion/abort/error
//  Revision : 1.0 - initial release
// ============================================================================
module prime_job_ctrl #(
    parameter int FIFO_DEPTH  = 8,
    parameter int ENG_TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        n_reset,
    input  logic [15:0] saddress,
    input  logic        srd,
    input  logic        swr,
    input  logic [31:0] sdata_in,
    output logic [31:0] sdata_out,
    output logic        eng_start,
    output logic [31:0] eng_cand,
    input  logic        eng_ready,
    input  logic        eng_done,
    input  logic        eng_is_prime,
    output logic [31:0] gpio_out,
    output logic        irq
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int TMO_W = $clog2(ENG_TIMEOUT + 1);

    localparam logic [CNT_W-1:0] c_FIFO_FULL = CNT_W'(FIFO_DEPTH);
    localparam logic [TMO_W-1:0] c_TMO_LAST  = TMO_W'(ENG_TIMEOUT - 1);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_ISSUE = 2'd1;
    localparam logic [1:0] c_ST_WAIT  = 2'd2;
    localparam logic [1:0] c_ST_DONE  = 2'd3;

    localparam logic [1:0] c_S_IDLE  = 2'd0;
    localparam logic [1:0] c_S_BUSY  = 2'd1;
    localparam logic [1:0] c_S_DONE  = 2'd2;
    localparam logic [1:0] c_S_FAIL  = 2'd3;

    localparam logic [15:0] c_ADDR_JOB  = 16'h0100;
    localparam logic [15:0] c_ADDR_CTL  = 16'h0104;
    localparam logic [15:0] c_ADDR_W    = 16'h0110;
    localparam logic [15:0] c_ADDR_STAT = 16'h0120;
    localparam logic [15:0] c_ADDR_FIFO = 16'h0130;
    localparam logic [15:0] c_ADDR_FND  = 16'h0140;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]       state_q, state_d;
    logic [31:0]      a_q, a_d;
    logic [31:0]      w_q, w_d;
    logic [31:0]      found_q, found_d;
    logic [31:0]      cand_q, cand_d;
    logic [1:0]       s_q, s_d;
    logic             err_q, err_d;
    logic             ovf_q, ovf_d;
    logic [15:0]      gpio_q, gpio_d;
    logic             irq_q, irq_d;
    logic             start_q, start_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             srd_q, swr_q;
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      fifo_mem [FIFO_DEPTH];

    // ------------------------------------------------------------------
    // Bus decode and event qualification
    // ------------------------------------------------------------------
    logic        w_rd_fire, w_wr_fire;
    logic        w_wr_job, w_abort, w_clear;
    logic        w_busy, w_abort_act;
    logic        w_done, w_hit;
    logic        w_fifo_full, w_pop, w_push, w_push_drop;
    logic [31:0] w_found_post;

    assign w_rd_fire = srd & ~srd_q;
    assign w_wr_fire = swr & ~swr_q;
    assign w_wr_job  = w_wr_fire && (saddress == c_ADDR_JOB);
    assign w_abort   = w_wr_fire && (saddress == c_ADDR_CTL) && sdata_in[0];
    assign w_clear   = w_wr_fire && (saddress == c_ADDR_CTL) && sdata_in[1];

    assign w_busy      = (state_q == c_ST_ISSUE) || (state_q == c_ST_WAIT);
    assign w_abort_act = w_abort & w_busy;
    // An abort in the same cycle as a result discards the result.
    assign w_done      = eng_done && (state_q == c_ST_WAIT) && !w_abort_act;
    assign w_hit       = w_done & eng_is_prime;
    assign w_found_post = eng_is_prime ? (found_q + 32'd1) : found_q;

    assign w_fifo_full = (cnt_q == c_FIFO_FULL);
    assign w_pop       = w_rd_fire && (saddress == c_ADDR_FIFO) && (cnt_q != '0);
    // A pop in the same cycle frees a slot, so a full FIFO still accepts the push.
    assign w_push      = w_hit && !w_clear && (!w_fifo_full || w_pop);
    assign w_push_drop = w_hit && !w_clear && w_fifo_full && !w_pop;

    // ------------------------------------------------------------------
    // Process 1: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q <= c_ST_IDLE;
            a_q     <= '0;
            w_q     <= '0;
            found_q <= '0;
            cand_q  <= '0;
            s_q     <= c_S_IDLE;
            err_q   <= 1'b0;
            ovf_q   <= 1'b0;
            gpio_q  <= '0;
            irq_q   <= 1'b0;
            start_q <= 1'b0;
            tmo_q   <= '0;
            rdata_q <= '0;
            srd_q   <= 1'b0;
            swr_q   <= 1'b0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            w_q     <= w_d;
            found_q <= found_d;
            cand_q  <= cand_d;
            s_q     <= s_d;
            err_q   <= err_d;
            ovf_q   <= ovf_d;
            gpio_q  <= gpio_d;
            irq_q   <= irq_d;
            start_q <= start_d;
            tmo_q   <= tmo_d;
            rdata_q <= rdata_d;
            srd_q   <= srd;
            swr_q   <= swr;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            cnt_q   <= cnt_d;
        end
    end

    // FIFO storage has no reset; occupancy is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (w_push) begin
            fifo_mem[wptr_q] <= cand_q;
        end
    end

    // ------------------------------------------------------------------
    // Process 2: next-state and datapath
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        w_d     = w_q;
        found_d = found_q;
        cand_d  = cand_q;
        s_d     = s_q;
        err_d   = err_q;
        ovf_d   = ovf_q;
        gpio_d  = gpio_q;
        irq_d   = 1'b0;
        start_d = 1'b0;
        tmo_d   = tmo_q;
        rdata_d = rdata_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        cnt_d   = cnt_q;

        // Job register only accepts writes while idle.
        if (w_wr_job) begin
            if (state_q == c_ST_IDLE) begin
                a_d = sdata_in;
            end else begin
                err_d = 1'b1;
            end
        end

        case (state_q)
            c_ST_IDLE: begin
                if (w_wr_job) begin
                    if (sdata_in != 32'd0) begin
                        cand_d  = 32'd2;
                        found_d = '0;
                        w_d     = '0;
                        err_d   = 1'b0;
                        s_d     = c_S_BUSY;
                        state_d = c_ST_ISSUE;
                    end else begin
                        s_d     = c_S_DONE;
                        w_d     = '0;
                        found_d = '0;
                        irq_d   = 1'b1;
                    end
                end
            end
            c_ST_ISSUE: begin
                if (w_abort_act) begin
                    s_d     = c_S_FAIL;
                    irq_d   = 1'b1;
                    state_d = c_ST_IDLE;
                end else if (eng_ready) begin
                    start_d = 1'b1;
                    tmo_d   = '0;
                    state_d = c_ST_WAIT;
                end
            end
            c_ST_WAIT: begin
                if (w_abort_act) begin
                    s_d     = c_S_FAIL;
                    irq_d   = 1'b1;
                    state_d = c_ST_IDLE;
                end else if (w_done) begin
                    if (eng_is_prime) begin
                        w_d     = cand_q;
                        found_d = w_found_post;
                    end
                    if (w_found_post == a_q) begin
                        state_d = c_ST_DONE;
                    end else if (cand_q == 32'hFFFF_FFFF) begin
                        // Candidate space exhausted before reaching the target.
                        err_d   = 1'b1;
                        s_d     = c_S_FAIL;
                        irq_d   = 1'b1;
                        state_d = c_ST_IDLE;
                    end else begin
                        cand_d  = cand_q + 32'd1;
                        state_d = c_ST_ISSUE;
                    end
                end else if (tmo_q == c_TMO_LAST) begin
                    err_d   = 1'b1;
                    s_d     = c_S_FAIL;
                    irq_d   = 1'b1;
                    state_d = c_ST_IDLE;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            c_ST_DONE: begin
                s_d     = c_S_DONE;
                gpio_d  = gpio_q + found_q[15:0];
                irq_d   = 1'b1;
                state_d = c_ST_IDLE;
            end
            default: begin
                state_d = c_ST_IDLE;
            end
        endcase

        // Result FIFO; clear overrides a concurrent push.
        if (w_clear) begin
            wptr_d = '0;
            rptr_d = '0;
            cnt_d  = '0;
            ovf_d  = 1'b0;
        end else begin
            if (w_push) begin
                wptr_d = wptr_q + PTR_W'(1);
            end
            if (w_pop) begin
                rptr_d = rptr_q + PTR_W'(1);
            end
            cnt_d = cnt_q + CNT_W'(w_push) - CNT_W'(w_pop);
            if (w_push_drop) begin
                ovf_d = 1'b1;
            end
        end

        // Read data is captured on the strobe edge and held until the next read.
        if (w_rd_fire) begin
            case (saddress)
                c_ADDR_W:    rdata_d = w_q;
                c_ADDR_STAT: rdata_d = {16'h0, 8'(cnt_q), 2'b00, ovf_q, err_q, 2'b00, s_q};
                c_ADDR_FIFO: rdata_d = (cnt_q != '0) ? fifo_mem[rptr_q] : 32'd0;
                c_ADDR_FND:  rdata_d = found_q;
                default:     rdata_d = 32'd0;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Process 3: outputs
    // ------------------------------------------------------------------
    always_comb begin
        eng_start = start_q;
        eng_cand  = cand_q;
        irq       = irq_q;
        gpio_out  = {16'h0, gpio_q};
        sdata_out = rdata_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_prime_job_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_prime_job_ctrl
//  Purpose  : Scoreboard bench for prime_job_ctrl with a behavioural engine
//             and a job-level reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_prime_job_ctrl;

    localparam int DEPTH = 8;
    localparam int TMO   = 1024;

    logic        clk = 1'b0;
    logic        n_reset = 1'b0;
    logic [15:0] saddress = '0;
    logic        srd = 1'b0;
    logic        swr = 1'b0;
    logic [31:0] sdata_in = '0;
    logic [31:0] sdata_out;
    logic        eng_start;
    logic [31:0] eng_cand;
    logic        eng_ready = 1'b1;
    logic        eng_done = 1'b0;
    logic        eng_is_prime = 1'b0;
    logic [31:0] gpio_out;
    logic        irq;

    prime_job_ctrl #(.FIFO_DEPTH(DEPTH), .ENG_TIMEOUT(TMO)) dut (
        .clk          (clk),
        .n_reset      (n_reset),
        .saddress     (saddress),
        .srd          (srd),
        .swr          (swr),
        .sdata_in     (sdata_in),
        .sdata_out    (sdata_out),
        .eng_start    (eng_start),
        .eng_cand     (eng_cand),
        .eng_ready    (eng_ready),
        .eng_done     (eng_done),
        .eng_is_prime (eng_is_prime),
        .gpio_out     (gpio_out),
        .irq          (irq)
    );

    initial forever #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference model state ----------------
    int unsigned mq[$];
    bit          m_ovf = 1'b0;
    bit          m_err = 1'b0;
    logic [1:0]  m_s = 2'd0;
    int unsigned m_w = 0;
    int unsigned m_found = 0;
    logic [15:0] m_gpio = 16'h0;

    // ---------------- scoreboard ----------------
    logic [31:0] exp_q[$];
    string       name_q[$];
    int          irq_cnt = 0;

    // ---------------- engine controls ----------------
    int          lat_fixed = 3;
    bit          lat_rand = 1'b0;
    bit          mute = 1'b0;
    int unsigned abort_cand = 0;
    int          abort_cyc = -1;
    int          start_cyc = 0;

    function automatic bit is_prime_f(input int unsigned n);
        if (n < 2) return 1'b0;
        for (int unsigned d = 2; d * d <= n; d++) begin
            if (n % d == 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic logic [31:0] status_exp();
        return {16'h0, 8'(mq.size()), 2'b00, m_ovf, m_err, 2'b00, m_s};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Job-level model: walk candidates, stop at the target count or at the
    // candidate whose result gets discarded by an abort.
    task automatic model_job(input int unsigned a, input int unsigned stop_at);
        int unsigned n;
        int unsigned f;
        if (a == 0) begin
            m_s = 2'd2; m_w = 0; m_found = 0;
            return;
        end
        m_err = 1'b0; m_w = 0; f = 0; n = 2;
        while (f < a && n != stop_at) begin
            if (is_prime_f(n)) begin
                f++;
                m_w = n;
                if (mq.size() < DEPTH) mq.push_back(n);
                else m_ovf = 1'b1;
            end
            n++;
        end
        m_found = f;
        if (f == a) begin
            m_s = 2'd2;
            m_gpio = m_gpio + 16'(f);
        end else begin
            m_s = 2'd3;
        end
    endtask

    // ---------------- bus driver ----------------
    task automatic pulse(input bit is_rd, input logic [15:0] a, input logic [31:0] d);
        int plen = $urandom_range(1, 3);
        @(negedge clk);
        saddress = a; sdata_in = d;
        if (is_rd) srd = 1'b1; else swr = 1'b1;
        repeat (plen) @(negedge clk);
        srd = 1'b0; swr = 1'b0;
    endtask

    task automatic bus_read(input logic [15:0] a, input logic [31:0] e, input string nm);
        exp_q.push_back(e);
        name_q.push_back(nm);
        pulse(1'b1, a, 32'h0);
    endtask

    task automatic start_job(input int unsigned a, input int unsigned stop_at);
        model_job(a, stop_at);
        pulse(1'b0, 16'h0100, a);
    endtask

    task automatic fifo_clear();
        pulse(1'b0, 16'h0104, 32'h2);
        mq.delete();
        m_ovf = 1'b0;
    endtask

    task automatic wait_job(input int base, input int bound, input string nm);
        bit ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (irq_cnt > base) begin ok = 1'b1; break; end
        end
        chk({nm, "_irq_seen"}, 32'(ok), 32'd1);
    endtask

    task automatic check_regs(input string nm);
        bus_read(16'h0110, m_w, {nm, "_W"});
        bus_read(16'h0140, m_found, {nm, "_found"});
        bus_read(16'h0120, status_exp(), {nm, "_status"});
        chk({nm, "_gpio"}, gpio_out, {16'h0, m_gpio});
    endtask

    task automatic pop_check(input int k, input string nm);
        logic [31:0] e;
        for (int i = 0; i < k; i++) begin
            e = (mq.size() != 0) ? mq.pop_front() : 32'd0;
            bus_read(16'h0130, e, {nm, "_pop"});
        end
    endtask

    // ---------------- monitor: read data ----------------
    initial begin : mon_rd
        logic prev;
        logic [31:0] e;
        string nm;
        prev = 1'b0;
        forever begin
            @(posedge clk);
            if (srd && !prev && n_reset) begin
                @(negedge clk);
                if (exp_q.size() == 0) begin
                    n_cmp++; n_mis++;
                    $display("FAIL unexpected_read: got %h expected no read", sdata_out);
                end else begin
                    e  = exp_q.pop_front();
                    nm = name_q.pop_front();
                    chk(nm, sdata_out, e);
                end
                prev = 1'b1;
            end else begin
                prev = srd;
            end
        end
    end

    // ---------------- monitor: irq pulses ----------------
    initial begin : mon_irq
        logic last;
        last = 1'b0;
        forever begin
            @(negedge clk);
            if (irq) begin
                irq_cnt++;
                n_cmp++;
                if (last) begin
                    n_mis++;
                    $display("FAIL irq_width: got 2+ consecutive high cycles expected 1");
                end
            end
            last = irq;
        end
    end

    // ---------------- engine model ----------------
    initial begin : engine
        int unsigned c;
        int lat;
        forever begin
            @(negedge clk);
            if (eng_start && n_reset) begin
                c = eng_cand;
                start_cyc = cyc;
                eng_ready = 1'b0;
                if (!mute) begin
                    lat = lat_rand ? int'($urandom_range(1, 5)) : lat_fixed;
                    if (abort_cand != 0 && c == abort_cand) abort_cyc = cyc + lat;
                    repeat (lat) @(negedge clk);
                    eng_done = 1'b1;
                    eng_is_prime = is_prime_f(c);
                    @(negedge clk);
                    eng_done = 1'b0;
                    eng_is_prime = 1'b0;
                    if (lat_rand) repeat ($urandom_range(0, 2)) @(negedge clk);
                end
                eng_ready = 1'b1;
            end
        end
    end

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence ----------------
    initial begin : main
        int base;
        int a;
        bit ok;
        bit sent;

        repeat (3) @(negedge clk);
        chk("rst_sdata_out", sdata_out, 32'h0);
        chk("rst_eng_start", 32'(eng_start), 32'h0);
        chk("rst_eng_cand", eng_cand, 32'h0);
        chk("rst_gpio", gpio_out, 32'h0);
        chk("rst_irq", 32'(irq), 32'h0);
        n_reset = 1'b1;
        repeat (2) @(negedge clk);
        bus_read(16'h0120, 32'h0, "rst_status");
        bus_read(16'h0110, 32'h0, "rst_W");
        bus_read(16'h0140, 32'h0, "rst_found");
        pop_check(1, "rst_empty");

        // Job A=5, fixed 3-cycle engine latency
        base = irq_cnt;
        start_job(5, 0);
        wait_job(base, 2000, "job5");
        check_regs("job5");
        pop_check(6, "job5");
        chk("job5_irq_count", irq_cnt - base, 32'd1);

        // Job A=4, then A=3 with a rejected job write mid-run
        base = irq_cnt;
        start_job(4, 0);
        wait_job(base, 2000, "job4");
        check_regs("job4");
        fifo_clear();
        base = irq_cnt;
        start_job(3, 0);
        pulse(1'b0, 16'h0100, 32'd9);
        m_err = 1'b1;
        wait_job(base, 2000, "job3");
        check_regs("job3");

        // FIFO overflow: A=10 without pops
        fifo_clear();
        base = irq_cnt;
        start_job(10, 0);
        wait_job(base, 3000, "ovf");
        check_regs("ovf");
        pop_check(9, "ovf");

        // Engine timeout
        mute = 1'b1;
        base = irq_cnt;
        pulse(1'b0, 16'h0100, 32'd1);
        m_err = 1'b1; m_s = 2'd3; m_w = 0; m_found = 0;
        ok = 1'b0;
        for (int i = 0; i < TMO + 200; i++) begin
            @(negedge clk);
            if (irq) begin ok = 1'b1; break; end
        end
        chk("tmo_irq_seen", 32'(ok), 32'd1);
        chk("tmo_cycles", cyc - start_cyc, TMO);
        mute = 1'b0;
        check_regs("tmo");

        // Abort coinciding with a prime result for candidate 7
        fifo_clear();
        abort_cand = 7;
        base = irq_cnt;
        start_job(10, 7);
        ok = 1'b0; sent = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (swr) swr = 1'b0;
            if (irq) begin ok = 1'b1; break; end
            if (!sent && cyc == abort_cyc) begin
                saddress = 16'h0104; sdata_in = 32'h1; swr = 1'b1; sent = 1'b1;
            end
        end
        swr = 1'b0;
        abort_cand = 0; abort_cyc = -1;
        chk("abort_irq_seen", 32'(ok), 32'd1);
        repeat (6) @(negedge clk);
        check_regs("abort");
        chk("abort_irq_count", irq_cnt - base, 32'd1);

        // Randomised jobs with random engine timing, pops and clears
        lat_rand = 1'b1;
        for (int j = 0; j < 6; j++) begin
            if ($urandom_range(0, 2) == 0) fifo_clear();
            a = int'($urandom_range(0, 12));
            base = irq_cnt;
            start_job(a, 0);
            wait_job(base, 3000, "rnd");
            repeat (2) @(negedge clk);
            check_regs("rnd");
            pop_check(int'($urandom_range(0, mq.size() + 1)), "rnd");
            chk("rnd_irq_count", irq_cnt - base, 32'd1);
        end
        lat_rand = 1'b0;

        // Reset in the middle of a job
        pulse(1'b0, 16'h0100, 32'd20);
        repeat (25) @(negedge clk);
        n_reset = 1'b0;
        #1;
        chk("midrst_sdata_out", sdata_out, 32'h0);
        chk("midrst_eng_start", 32'(eng_start), 32'h0);
        chk("midrst_eng_cand", eng_cand, 32'h0);
        chk("midrst_gpio", gpio_out, 32'h0);
        chk("midrst_irq", 32'(irq), 32'h0);
        mq.delete();
        m_ovf = 1'b0; m_err = 1'b0; m_s = 2'd0; m_w = 0; m_found = 0; m_gpio = 16'h0;
        repeat (3) @(negedge clk);
        n_reset = 1'b1;
        repeat (30) @(negedge clk);
        check_regs("postrst");

        repeat (5) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
`default_nettype wire
